// File: rtl/msp430_pkg.sv
// rtl/msp430_pkg.sv - shared encodings for the register write-back sequencer
package msp430_pkg;

   // Write-back data source select
   localparam logic [1:0] MD_ALU = 2'd0;
   localparam logic [1:0] MD_MDB = 2'd1;
   localparam logic [1:0] MD_INC = 2'd2;
   localparam logic [1:0] MD_ILL = 2'd3;

   // Sequencer states: WRITE carries the destination write, INC the pointer bump
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      INC   = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_src_mux.sv
// rtl/wb_src_mux.sv - write-back data select, byte masking and auto-increment step
module wb_src_mux
   import msp430_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 4,
   parameter int WORD_REGS = 2
) (
   input  logic [1:0]        md,
   input  logic              bw,
   input  logic [REG_AW-1:0] src,
   input  logic [DATA_W-1:0] f_out,
   input  logic [DATA_W-1:0] mdb_out,
   input  logic [DATA_W-1:0] sout,
   output logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] step
);

   localparam logic [REG_AW-1:0] WORD_LIM = REG_AW'(WORD_REGS);

   logic [DATA_W-1:0] sel;
   logic              hi_clr;

   // PC/SP keep word alignment, so they always step by 2 even for byte ops
   assign step = (!bw || (src < WORD_LIM)) ? DATA_W'(2) : DATA_W'(1);

   // Pick the raw write data; the increment path wraps naturally at DATA_W bits
   always_comb begin
      sel = '0;
      case (md)
         MD_ALU:  sel = f_out;
         MD_MDB:  sel = mdb_out;
         MD_INC:  sel = sout + step;
         default: sel = '0;
      endcase
   end

   // Byte ops clear the upper bits of ALU/bus data; pointer increments are never masked
   assign hi_clr = bw && ((md == MD_ALU) || (md == MD_MDB));
   assign data   = hi_clr ? {{(DATA_W-8){1'b0}}, sel[7:0]} : sel;

endmodule

// File: rtl/reg_writeback_seq.sv
// rtl/reg_writeback_seq.sv - register file write-back sequencer with @Rn+ serialisation
module reg_writeback_seq
   import msp430_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 4,
   parameter int WORD_REGS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [1:0]        wb_md,
   input  logic              wb_autoinc,
   input  logic              wb_bw,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic [REG_AW-1:0] wb_src,
   input  logic [DATA_W-1:0] f_out,
   input  logic [DATA_W-1:0] mdb_out,
   input  logic [DATA_W-1:0] sout,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_din,
   output logic              md_done,
   output logic              wb_err
);

   wb_state_t         state_q, state_d;
   logic              we_q, we_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              inc_pend_q, inc_pend_d;
   logic [REG_AW-1:0] src_q, src_d;
   logic [DATA_W-1:0] inc_sum_q, inc_sum_d;

   logic [DATA_W-1:0] mux_data;
   logic [DATA_W-1:0] mux_step;
   logic              need_inc;

   wb_src_mux #(
      .DATA_W    (DATA_W),
      .REG_AW    (REG_AW),
      .WORD_REGS (WORD_REGS)
   ) u_mux (
      .md      (wb_md),
      .bw      (wb_bw),
      .src     (wb_src),
      .f_out   (f_out),
      .mdb_out (mdb_out),
      .sout    (sout),
      .data    (mux_data),
      .step    (mux_step)
   );

   // md=2 is itself the increment, so a second write is only needed for md 0/1
   assign need_inc = wb_autoinc && (wb_md != MD_INC);

   // Next state and next output values; outputs are loaded on the edge entering a state
   always_comb begin
      state_d    = state_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      din_d      = din_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      inc_pend_d = inc_pend_q;
      src_d      = src_q;
      inc_sum_d  = inc_sum_q;
      case (state_q)
         IDLE: begin
            if (wb_valid) begin
               if (wb_md == MD_ILL) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = WRITE;
                  we_d       = 1'b1;
                  waddr_d    = wb_dst;
                  din_d      = mux_data;
                  done_d     = !need_inc;
                  inc_pend_d = need_inc;
                  src_d      = wb_src;
                  inc_sum_d  = sout + mux_step;
               end
            end
         end
         WRITE: begin
            if (inc_pend_q) begin
               state_d = INC;
               we_d    = 1'b1;
               waddr_d = src_q;
               din_d   = inc_sum_q;
               done_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         INC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, capture and output registers; reset drops any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         din_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         inc_pend_q <= 1'b0;
         src_q      <= '0;
         inc_sum_q  <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         din_q      <= din_d;
         done_q     <= done_d;
         err_q      <= err_d;
         inc_pend_q <= inc_pend_d;
         src_q      <= src_d;
         inc_sum_q  <= inc_sum_d;
      end
   end

   assign wb_ready = (state_q == IDLE);
   assign rf_we    = we_q;
   assign rf_waddr = waddr_q;
   assign rf_din   = din_q;
   assign md_done  = done_q;
   assign wb_err   = err_q;

endmodule
